// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential fetch with stall hold, redirect flush and range halt.
// Define IFU_MISALIGN_TRAP_EN to make misaligned redirect targets halt until reset.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] MEM_TOP  = 32'd496
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        trap_q, trap_d;
  logic        redirect_ok;
  logic        misalign;
  logic        consume;

`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign    = (redirect_target[1:0] != 2'b00);
  assign redirect_ok = redirect_valid && !trap_q;
`else
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^redirect_target[1:0];
  assign misalign        = 1'b0;
  assign redirect_ok     = redirect_valid;
`endif

  assign consume = (state_q == RUN) && !stall && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      cnt_q     <= cnt_d;
      trap_q    <= trap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    trap_d    = trap_q;
    cnt_d     = cnt_q + {31'd0, consume};

    if (redirect_ok) begin
      if (misalign) begin
        state_d = HALT;
        trap_d  = 1'b1;
      end else begin
        pc_d    = {redirect_target[31:2], 2'b00};
        state_d = FLUSH;
      end
    end else begin
      // Entering RUN moves pc into resp_pc; out-of-range pc halts with no update.
      if (state_q == BOOT || state_q == FLUSH || (state_q == RUN && !stall)) begin
        if (pc_q > MEM_TOP) begin
          state_d = HALT;
        end else begin
          state_d   = RUN;
          resp_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
        end
      end
    end
  end

  always_comb begin
    if_valid  = 1'b0;
    halted    = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      RUN: begin
        if_valid  = 1'b1;
        imem_addr = stall ? resp_pc_q : pc_q;
      end
      HALT: begin
        halted    = 1'b1;
        imem_addr = resp_pc_q;
      end
      default: imem_addr = pc_q;
    endcase
  end

  assign if_instr    = imem_instr;
  assign if_pc       = resp_pc_q;
  assign if_pc_plus4 = resp_pc_q + 32'd4;
  assign fetch_count = cnt_q;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter MEM_TOP, 32'd496, highest legal word-aligned fetch address.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  byte address to the instruction memory; memory returns the big-endian word at that address on imem_instr after the next posedge.
REQ-006 imem_instr  input  32  registered instruction word from the memory.
REQ-007 stall  input  1  downstream cannot accept; current output is held.
REQ-008 redirect_valid  input  1  branch/jump taken; has priority over stall.
REQ-009 redirect_target  input  32  new fetch byte address.
REQ-010 if_valid  output  1  if_instr/if_pc carry a valid instruction.
REQ-011 if_instr  output  32  fetched instruction (imem_instr passed through).
REQ-012 if_pc  output  32  byte address of if_instr.
REQ-013 if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
REQ-014 halted  output  1  fetch stopped (out-of-range or misaligned).
REQ-015 fetch_count  output  32  number of instructions consumed since reset.

Function
REQ-016 The unit SHALL hold registers pc (address to present next), resp_pc (address of word on imem_instr) and a state in {BOOT, RUN, FLUSH, HALT}.
REQ-017 BOOT: imem_addr = pc, if_valid = 0; next edge -> RUN, resp_pc <= pc, pc <= pc + 4.
REQ-018 RUN: if_valid = 1, if_instr = imem_instr, if_pc = resp_pc; imem_addr = stall ? resp_pc : pc.
REQ-019 RUN, stall = 1, no redirect: pc and resp_pc unchanged; memory re-reads resp_pc so if_instr stays constant for the whole stall.
REQ-020 RUN, stall = 0, no redirect: resp_pc <= pc, pc <= pc + 4, fetch_count increments; one instruction per cycle, one-cycle memory latency fully hidden.
REQ-021 Consumption SHALL be defined as if_valid & !stall & !redirect_valid; fetch_count increments only on consumption, wraps 32'hFFFF_FFFF -> 0.
REQ-022 redirect_valid = 1 in BOOT, RUN or FLUSH: next edge pc <= aligned target, state -> FLUSH; the current output is discarded and not counted.
REQ-023 FLUSH: imem_addr = pc, if_valid = 0; next edge -> RUN, resp_pc <= pc, pc <= pc + 4 (stall ignored); redirect penalty is exactly one bubble cycle.
REQ-024 pc + 4 SHALL wrap modulo 2^32 without error.
REQ-025 When a transition into RUN would set resp_pc > MEM_TOP, state -> HALT instead; HALT: if_valid = 0, halted = 1, imem_addr = resp_pc, no register updates.
REQ-026 redirect_valid in HALT caused by out-of-range SHALL behave as REQ-022 and clear halted.
REQ-027 Simultaneous stall and redirect_valid: redirect wins.

Reset
REQ-028 rst_n low SHALL immediately force state = BOOT, pc = RESET_PC, resp_pc = RESET_PC, fetch_count = 0, halted = 0, if_valid = 0, independent of clk.
REQ-029 Reset asserted mid-stall, mid-flush or in HALT SHALL discard all in-flight fetches; first valid output is RESET_PC one edge after rst_n rises.

Configuration
REQ-030 Macro IFU_MISALIGN_TRAP_EN defined: redirect_target[1:0] != 0 SHALL put the unit in HALT with halted = 1, recoverable only by reset (redirects ignored).
REQ-031 IFU_MISALIGN_TRAP_EN undefined: redirect_target[1:0] SHALL be forced to 2'b00 and fetch continues normally.

Verification
REQ-032 Reset release, memory words 0x20080005, 0x20090003 at 0, 4, stall = 0 -> cycle 1 if_valid = 0; cycle 2 if_pc = 0, if_instr = 0x20080005; cycle 3 if_pc = 4.
REQ-033 stall high 3 cycles while if_pc = 8 -> if_instr and if_pc constant for 3 cycles, imem_addr = 8, fetch_count unchanged, then resumes at 12.
REQ-034 redirect_valid with target 0x40 while if_pc = 0x10 -> one cycle if_valid = 0, then if_pc = 0x40, 0x44; 0x10 not counted.
REQ-035 Sequential fetch to 496 with MEM_TOP = 496 -> if_pc = 496 valid, next cycle halted = 1, if_valid = 0; redirect to 0 restarts at 0.
REQ-036 With IFU_MISALIGN_TRAP_EN, redirect to 0x42 -> halted = 1 permanently until rst_n; without it -> fetch continues at 0x40.
REQ-037 rst_n pulsed low mid-stall at if_pc = 0x20 -> if_valid drops immediately, fetch_count = 0, restart at RESET_PC.
